leak_rx: RTL and testbench
==========================

# leak_rx

Covert-channel receiver for the HT1 adder Trojan: the capture side of the `trojan_out` leak pin. It taps the adder operand bits, reproduces the transmitter's run-length trigger to learn when the leak stream starts, and then deserialises the leaked carry bits into words. Words are delivered on a valid/ready port. It sits in the task_2 evaluation harness beside the Trojaned `full_adder` and feeds the bench scoreboard or the debug capture logic.

## Interface
Parameters:
- `TRIG_LEN`, default 8: number of consecutive matching operand samples that arm the receiver; range 2..15.
- `WORD_W`, default 8: number of leaked bits per output word; range 2..32.

Ports (clock and reset first):
- `clk` in 1: single clock for the whole block.
- `reset` in 1: synchronous, active-high reset.
- `a` in 1, `b` in 1, `cin` in 1: tapped adder operands, sampled every cycle.
- `leak_in` in 1: the Trojan leak pin, `trojan_out`.
- `clear` in 1: synchronous soft clear. Same effect as `reset`, except the `overrun` and `word_cnt` outputs are kept.
- `word_data` out WORD_W: assembled word.
- `word_valid` out 1: `word_data` holds an undelivered word.
- `word_ready` in 1: downstream accepts the word.
- `armed` out 1: trigger seen. Sticky until reset or clear.
- `overrun` out 1: sticky; set when a completed word was dropped.
- `word_cnt` out 16: count of words delivered (see Configuration).

## Operation
- Trigger pattern: {a,b,cin} == 3'b101. A run counter increments on every matching sample and clears to 0 on any non-matching sample. The counter saturates at TRIG_LEN.
- FSM states, one transition per edge:
  - IDLE: counting. Go to WAIT on the edge where the TRIG_LEN-th consecutive match is sampled; `armed` rises on that same edge.
  - WAIT: lasts one cycle, which matches the transmitter's one-cycle leak register. Go to CAPTURE.
  - CAPTURE: shift in `leak_in` on every edge. Remain in CAPTURE until reset or clear.
- In CAPTURE, operand activity is ignored; a mismatch does not disarm.
- Bit order: the k-th captured bit goes to bit k of the word (LSB first). A bit counter wraps from WORD_W-1 to 0.
- Word completion, on the edge that captures bit WORD_W-1:
  - The word loads into the holding register if the register is empty or is being drained that cycle (`word_valid && word_ready`).
  - Otherwise the new word is dropped, `overrun` is set, and the held word is kept.
- Handshake:
  - `word_valid` stays high until the cycle where `word_ready` is sampled high.
  - `word_data` is stable while `word_valid` is high.
  - `word_ready` with no valid word has no effect.
- Simultaneous events: `reset` beats `clear`; `clear` beats every capture and handshake event in the same cycle.
- Reset values: state IDLE, run counter 0, bit counter 0, `armed`=0, `word_valid`=0, `word_data`=0, `overrun`=0, `word_cnt`=0. A reset mid-word discards the partial word.

## Timing
- Let E be the edge where the TRIG_LEN-th match is sampled.
  - E+1: the transmitter registers c1 onto its leak pin; the receiver moves to CAPTURE.
  - E+2: the first `leak_in` sample is captured.
- Word latency: the first word is valid after edge E+1+WORD_W. With continuous `word_ready`, a word is delivered every WORD_W cycles.
- Throughput: one bit per cycle, no bubbles.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- `LEAK_RX_STATS_EN` defined: `word_cnt` increments on each accepted handshake and saturates at 16'hFFFF.
- `LEAK_RX_STATS_EN` undefined: `word_cnt` is tied to 0 and the counter logic is not compiled in.

## Structure
- Package `leak_rx_pkg` holds:
  - `TRIG_PATTERN` = 3'b101;
  - default `TRIG_LEN` and `WORD_W`;
  - the FSM state typedef {IDLE, WAIT, CAPTURE}.
- Sub-module `leak_trig_detect`: pattern compare plus saturating run counter, with a one-cycle `hit` output. The FSM, shifter, holding register and stats stay in `leak_rx`.

## Test plan
- Trigger run: 3'b101 for 7 cycles, then 3'b000, then 3'b101 for 8 cycles → `armed` stays 0 after the 7-cycle run and rises on the 8th match of the second run.
- Normal capture: arm, then `leak_in` = 1,0,1,1,0,0,1,0 with `word_ready`=1 → `word_data`=8'h4D, `word_valid` high for 1 cycle at E+9.
- Backpressure: `word_ready`=0 across two completed words → the first word is held unchanged, `overrun`=1, and the second word is lost. Raising `word_ready` delivers the first word.
- Drain and complete in the same cycle: `word_ready` pulses on the edge where the next word completes → the new word loads with no overrun.
- Mid-operation reset and clear: `reset` after 5 captured bits → all outputs return to reset values and re-arming needs a full new run. `clear` with `overrun`=1 → `overrun` stays 1 and `armed`=0.
- Stats (macro defined): deliver 3 words → `word_cnt`=3. Build without the macro → `word_cnt`=0.

Source files
------------

// File: rtl/leak_rx_pkg.sv
// Shared constants and FSM state type for the HT1 leak-pin receiver.
// Both leak_rx and leak_trig_detect import this package.
package leak_rx_pkg;

    localparam logic [2:0] TRIG_PATTERN = 3'b101;
    localparam int         DEF_TRIG_LEN = 8;
    localparam int         DEF_WORD_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CAPTURE
    } rx_state_e;

endpackage

// File: rtl/leak_trig_detect.sv
// Run-length trigger detector for the {a,b,cin} pattern.
// It pulses hit on the sample that completes the TRIG_LEN-th consecutive match.
module leak_trig_detect
    import leak_rx_pkg::*;
#(
    parameter int TRIG_LEN = DEF_TRIG_LEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [2:0] operands,
    output logic       hit
);

    localparam int CW = 4;

    logic [CW-1:0] run_q;
    logic [CW-1:0] run_d;
    logic          match;

    // The counter saturates so that hit fires only once per run.
    always_comb begin
        match = (operands == TRIG_PATTERN);
        run_d = '0;
        if (match) begin
            run_d = (run_q == CW'(TRIG_LEN)) ? run_q : run_q + 1'b1;
        end
        hit = match && (run_q == CW'(TRIG_LEN - 1));
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/leak_rx.sv
// Covert-channel receiver: arms on the operand trigger, then deserialises leak_in LSB first.
// Optional LEAK_RX_STATS_EN builds a saturating delivered-word counter on word_cnt.
module leak_rx
    import leak_rx_pkg::*;
#(
    parameter int TRIG_LEN = DEF_TRIG_LEN,
    parameter int WORD_W   = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a,
    input  logic              b,
    input  logic              cin,
    input  logic              leak_in,
    input  logic              clear,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              armed,
    output logic              overrun,
    output logic [15:0]       word_cnt
);

    localparam int BW = $clog2(WORD_W);

    rx_state_e         state_q, state_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              armed_q, armed_d;
    logic              ovr_q, ovr_d;
    logic              hit;
    logic              drain;

    leak_trig_detect #(
        .TRIG_LEN (TRIG_LEN)
    ) u_trig (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .operands ({a, b, cin}),
        .hit      (hit)
    );

    assign drain = valid_q && word_ready;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q && !drain;
        armed_d = armed_q;
        ovr_d   = ovr_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = WAIT;
                    armed_d = 1'b1;
                end
            end
            WAIT: state_d = CAPTURE;
            CAPTURE: begin
                shift_d[bit_q] = leak_in;
                if (bit_q == BW'(WORD_W - 1)) begin
                    bit_d = '0;
                    // A word being drained this cycle frees the holding register.
                    if (!valid_q || drain) begin
                        data_d  = shift_d;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d = IDLE;
            bit_d   = '0;
            shift_d = '0;
            data_d  = '0;
            valid_d = 1'b0;
            armed_d = 1'b0;
            ovr_d   = ovr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            armed_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            armed_q <= armed_d;
            ovr_q   <= ovr_d;
        end
    end

    assign word_data  = data_q;
    assign word_valid = valid_q;
    assign armed      = armed_q;
    assign overrun    = ovr_q;

`ifdef LEAK_RX_STATS_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (drain && !clear && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign word_cnt = cnt_q;
`else
    assign word_cnt = '0;
`endif

endmodule

// File: tb/tb_leak_rx.sv
// Self-checking bench for leak_rx: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the receiver.
module tb_leak_rx;

    localparam int TL = 8;
    localparam int W  = 8;
`ifdef LEAK_RX_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic         clk;
    logic         reset;
    logic         a;
    logic         b;
    logic         cin;
    logic         leak_in;
    logic         clear;
    logic         word_ready;
    logic [W-1:0] word_data;
    logic         word_valid;
    logic         armed;
    logic         overrun;
    logic [15:0]  word_cnt;

    int total = 0;
    int bad   = 0;

    // Model state: arming is tracked by edges elapsed since the trigger edge.
    int           mRun;
    bit           mArmed;
    int           mSince;
    bit           mBits[W];
    bit           mValid;
    bit           mOvr;
    logic [W-1:0] mData;
    int           mCnt;

    leak_rx #(
        .TRIG_LEN (TL),
        .WORD_W   (W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .leak_in    (leak_in),
        .clear      (clear),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .armed      (armed),
        .overrun    (overrun),
        .word_cnt   (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelEdge(input logic [2:0] ops, input logic leak, input logic clr,
                             input logic rdy, input logic rst);
        bit           drained;
        int           pos;
        logic [W-1:0] word;
        if (rst) begin
            mRun = 0; mArmed = 0; mSince = 0; mValid = 0; mOvr = 0; mData = '0; mCnt = 0;
        end else if (clr) begin
            mRun = 0; mArmed = 0; mSince = 0; mValid = 0; mData = '0;
        end else begin
            drained = mValid && rdy;
            if (drained && mCnt < 65535) mCnt++;
            if (drained) mValid = 0;
            if (!mArmed) begin
                mRun = (ops == 3'b101) ? ((mRun < TL) ? mRun + 1 : TL) : 0;
                if (mRun == TL) begin
                    mArmed = 1;
                    mSince = 0;
                end
            end else begin
                mSince++;
                if (mSince >= 2) begin
                    pos = (mSince - 2) % W;
                    mBits[pos] = leak;
                    if (pos == W - 1) begin
                        word = '0;
                        for (int k = 0; k < W; k++) word[k] = mBits[k];
                        if (!mValid) begin
                            mData  = word;
                            mValid = 1;
                        end else begin
                            mOvr = 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic [2:0] ops, input logic leak, input logic clr,
                                 input logic rdy, input logic rst);
        {a, b, cin} = ops;
        leak_in     = leak;
        clear       = clr;
        word_ready  = rdy;
        reset       = rst;
        @(posedge clk);
        modelEdge(ops, leak, clr, rdy, rst);
        #1;
        checkOutput("armed", armed, mArmed);
        checkOutput("valid", word_valid, mValid);
        checkOutput("data", word_data, mData);
        checkOutput("overrun", overrun, mOvr);
        checkOutput("wordCnt", word_cnt, STATS ? mCnt : 0);
    endtask

    task automatic armRun();
        for (int i = 0; i < TL; i++) applyStimulus(3'b101, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] pat;
        int         nextPos;
        logic       rdy;
        pat = 8'h4D;
        mRun = 0; mArmed = 0; mSince = 0; mValid = 0; mOvr = 0; mData = '0; mCnt = 0;

        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("resetArmed", armed, 0);
        checkOutput("resetValid", word_valid, 0);
        checkOutput("resetData", word_data, 0);
        checkOutput("resetOverrun", overrun, 0);

        // A 7-long run must not arm; a following 8-long run arms on its last match.
        for (int i = 0; i < TL - 1; i++) applyStimulus(3'b101, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("armedAfter7", armed, 0);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < TL - 1; i++) applyStimulus(3'b101, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("armedBefore8th", armed, 0);
        applyStimulus(3'b101, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("armedAt8th", armed, 1);

        // Normal capture: WAIT cycle, then bits 1,0,1,1,0,0,1,0 give 8'h4D.
        applyStimulus(3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < W; i++) begin
            applyStimulus(3'b010, pat[i], 1'b0, 1'b1, 1'b0);
            if (i < W - 1) checkOutput("validEarly", word_valid, 0);
        end
        checkOutput("word4D", word_data, 8'h4D);
        checkOutput("valid4D", word_valid, 1);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("validOneCycle", word_valid, 0);

        // Backpressure across two completions: first word held, second dropped.
        for (int i = 0; i < 2 * W - 1; i++) applyStimulus(3'b000, 1'($urandom), 1'b0, 1'b0, 1'b0);
        checkOutput("bpOverrun", overrun, 1);
        checkOutput("bpValid", word_valid, 1);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("bpDelivered", word_valid, 0);

        // Soft clear keeps overrun and disarms.
        applyStimulus(3'b101, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("clearOverrun", overrun, 1);
        checkOutput("clearArmed", armed, 0);

        // Reset after five captured bits, then a full run is needed to re-arm.
        armRun();
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(3'b101, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("rstArmed", armed, 0);
        checkOutput("rstOverrun", overrun, 0);
        checkOutput("rstValid", word_valid, 0);
        for (int i = 0; i < TL - 1; i++) applyStimulus(3'b101, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rearmShort", armed, 0);
        applyStimulus(3'b101, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rearmFull", armed, 1);

        // Drain and complete on the same edge: ready pulses only on completion edges.
        for (int i = 0; i < 2 * W + 1; i++) begin
            nextPos = mSince - 1;
            rdy = (mValid && nextPos >= 0 && (nextPos % W) == W - 1);
            applyStimulus(3'b000, 1'($urandom), 1'b0, rdy, 1'b0);
        end
        checkOutput("sameEdgeOverrun", overrun, 0);
        checkOutput("sameEdgeValid", word_valid, 1);

        // Stats: three deliveries after a fresh reset.
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        armRun();
        for (int i = 0; i < 3 * W + 2; i++) applyStimulus(3'b000, 1'($urandom), 1'b0, 1'b1, 1'b0);
        checkOutput("stats3", word_cnt, STATS ? 3 : 0);

        // Randomized traffic biased toward the trigger pattern.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 9) < 7) ? 3'b101 : 3'($urandom),
                          1'($urandom),
                          ($urandom_range(0, 149) == 0),
                          1'($urandom),
                          ($urandom_range(0, 299) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
